vit_acs_sched: RTL and testbench
================================

# vit_acs_sched

Frame-level scheduler for the 64-state Viterbi decoder core. Accepts received symbol pairs on a valid/ready stream and issues one add-compare-select step per accepted pair to the shared BMC/ACS array. It also drives the survivor-memory write pointer, requests path-metric normalisation, and hands each completed frame to the traceback unit.

## Interface
- `SURV_AW`, default 10: survivor memory address width; memory depth is 2^SURV_AW trellis steps.
- `FRAME_MAX`, default 1000: maximum accepted pairs per frame, tail bits included; must be ≤ 2^SURV_AW.
- `TAIL`, default 6: tail steps per frame, equal to constraint length minus 1.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_pair` is valid.
- `in_ready` out 1: scheduler accepts `in_pair` this cycle.
- `in_pair` in 2: hard-decision received pair, {bit1, bit0}.
- `in_last` in 1: marks the final pair of the frame.
- `acs_en` out 1: ACS array performs one trellis step this cycle.
- `acs_pair` out 2: registered pair presented to the BMC units.
- `acs_init` out 1: one-cycle pulse; loads metric 0 into state 0 and the maximum metric into all other states.
- `pm_all_msb` in 1: every path metric has its MSB set.
- `norm_en` out 1: ACS clears the metric MSB on the step where this is asserted.
- `surv_we` out 1: survivor write enable, equal to `acs_en`.
- `surv_waddr` out SURV_AW: survivor write address.
- `tb_start` out 1: one-cycle pulse that launches traceback.
- `tb_last_addr` out SURV_AW: address of the final step in the frame.
- `tb_done` in 1: traceback finished, one-cycle pulse.
- `busy` out 1: scheduler is not in IDLE.
- `frame_err` out 1: sticky overflow/short-frame flag; cleared by the next `acs_init`.

## Operation
- FSM states: IDLE, INIT, RUN, TB_WAIT.
- IDLE → INIT: on `in_valid`. Nothing is accepted in IDLE.
- INIT: lasts 1 cycle; pulses `acs_init` and clears `surv_waddr` and the step count; then → RUN.
- RUN:
  - `in_ready` = 1.
  - On each handshake (`in_valid && in_ready`): register `in_pair` into `acs_pair`, assert `acs_en` and `surv_we` on the next cycle, and increment `surv_waddr` after that write.
  - `norm_en` = `pm_all_msb && acs_en`; it is sampled combinationally from the ACS array.
  - On a handshake with `in_last`: latch `tb_last_addr` = address written by that step, then → TB_WAIT.
- Overflow: the step count reaches FRAME_MAX with no `in_last`. Set `frame_err`, treat that pair as last, → TB_WAIT.
- Short frame: `in_last` arrives with step count < TAIL+1. Set `frame_err`, still go to traceback.
- TB_WAIT:
  - `in_ready` = 0.
  - `tb_start` pulses on the cycle after the final `acs_en`.
  - Wait for `tb_done`, then → IDLE.
  - A `tb_done` that arrives while not in TB_WAIT is ignored.
- Arithmetic: `surv_waddr` is an unsigned counter mod 2^SURV_AW; no wrap occurs within a legal frame. The step count is $clog2(FRAME_MAX+1) bits.

## Timing
- Reset values: `in_ready`, `acs_en`, `acs_init`, `norm_en`, `surv_we`, `tb_start`, `busy`, `frame_err` = 0; `acs_pair`, `surv_waddr`, `tb_last_addr` = 0; state = IDLE.
- Latency: handshake in cycle n → `acs_en` and `surv_we` in cycle n+1, at address k for the k-th pair (0-based).
- Throughput: 1 pair per cycle in RUN. Back-to-back frames lose the IDLE, INIT and TB_WAIT cycles.
- `acs_init` in cycle c → first `in_ready` in cycle c+1.
- Reset mid-frame aborts immediately. The ACS array and traceback are re-initialised by the next INIT; no `tb_start` is issued for the aborted frame.
- `in_valid` low in RUN: no step, no address advance; `acs_en` is low the next cycle.
- `tb_done` and a new `in_valid` in the same cycle: → IDLE, then INIT on the following cycle.

## Structure
- Shared package `vit_pkg`:
  - state enum `sched_state_t`
  - `N_STATES` = 64
  - `CONSTR_LEN` = 7
  - metric width `PM_W`
- One sub-module, `vit_step_cnt`: step counter plus write-address counter, with clear, enable and overflow compare.

## Test plan
- Reset, then a 10-pair frame of `in_pair` = 2'b11 with `in_last` on pair 10:
  - `acs_init` pulse, then `acs_en` ×10 at addresses 0–9.
  - `tb_last_addr` = 9; `tb_start` one cycle after the last step; `frame_err` = 0.
- 20-pair frame with `in_valid` deasserted on cycles 3–5: addresses stay contiguous 0–19 with no gaps; `acs_en` is low on the stalled cycles + 1.
- FRAME_MAX = 8 with no `in_last`: `frame_err` = 1 after pair 8; `tb_last_addr` = 7; the 9th pair is not accepted until the next INIT.
- Force `pm_all_msb` = 1 during step 4 only: `norm_en` is high for exactly one cycle, aligned with step 4's `acs_en`.
- Assert `rst_n` low during pair 5 of a frame: all outputs return to reset values immediately; the next frame starts at address 0 with `frame_err` = 0.
- `tb_done` coincident with `in_valid` for the next frame: IDLE for 1 cycle, `acs_init` on the next, and the new frame decodes normally.

Source files
------------

// File: rtl/vit_pkg.sv
// Shared definitions for the 64-state Viterbi decoder core.
//   sched_state_t : scheduler FSM states (IDLE, INIT, RUN, TB_WAIT)
//   N_STATES      : number of trellis states
//   CONSTR_LEN    : code constraint length (tail steps = CONSTR_LEN - 1)
//   PM_W          : path-metric width used by the ACS array
package vit_pkg;

    localparam int N_STATES   = 64;
    localparam int CONSTR_LEN = 7;
    localparam int PM_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INIT    = 2'd1,
        ST_RUN     = 2'd2,
        ST_TB_WAIT = 2'd3
    } sched_state_t;

endpackage

// File: rtl/vit_step_cnt.sv
// Step counter and survivor write-address counter for the ACS scheduler.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : clear both counters (frame start)
//   step_i       : a pair was accepted this cycle
//   wr_i         : a survivor column is written this cycle
//   step_cnt_o   : pairs accepted so far in this frame
//   waddr_o      : survivor write address for the current write
//   at_max_o     : the pair accepted now would be the FRAME_MAX-th one
module vit_step_cnt
    import vit_pkg::*;
#(
    parameter int SURV_AW   = 10,
    parameter int FRAME_MAX = 1000,
    parameter int CNT_W     = $clog2(FRAME_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               step_i,
    input  logic               wr_i,
    output logic [CNT_W-1:0]   step_cnt_o,
    output logic [SURV_AW-1:0] waddr_o,
    output logic               at_max_o
);

    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [SURV_AW-1:0] waddr_q, waddr_d;

    always_comb begin
        step_cnt_d = step_cnt_q;
        waddr_d    = waddr_q;
        if (clr_i) begin
            step_cnt_d = '0;
            waddr_d    = '0;
        end else begin
            if (step_i) step_cnt_d = step_cnt_q + 1'b1;
            // The address advances only after the write it addresses.
            if (wr_i)   waddr_d    = waddr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
            waddr_q    <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
            waddr_q    <= waddr_d;
        end
    end

    assign step_cnt_o = step_cnt_q;
    assign waddr_o    = waddr_q;
    assign at_max_o   = (step_cnt_q == CNT_W'(FRAME_MAX - 1));

endmodule

// File: rtl/vit_acs_sched.sv
// Frame-level scheduler for the Viterbi ACS array.
// Accepts received pairs on a valid/ready stream, issues one ACS step per
// pair, drives the survivor write pointer, requests metric normalisation and
// launches traceback at the end of each frame.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : input pair handshake; in_pair, in_last payload
//   acs_en, acs_pair        : one trellis step with its registered pair
//   acs_init                : metric initialisation pulse (INIT state)
//   pm_all_msb, norm_en     : normalisation request from/to the ACS array
//   surv_we, surv_waddr     : survivor memory write port
//   tb_start, tb_last_addr  : traceback launch and final step address
//   tb_done                 : traceback finished pulse
//   busy, frame_err         : status (not IDLE; sticky frame error)
module vit_acs_sched
    import vit_pkg::*;
#(
    parameter int SURV_AW   = 10,
    parameter int FRAME_MAX = 1000,
    parameter int TAIL      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_pair,
    input  logic               in_last,
    output logic               acs_en,
    output logic [1:0]         acs_pair,
    output logic               acs_init,
    input  logic               pm_all_msb,
    output logic               norm_en,
    output logic               surv_we,
    output logic [SURV_AW-1:0] surv_waddr,
    output logic               tb_start,
    output logic [SURV_AW-1:0] tb_last_addr,
    input  logic               tb_done,
    output logic               busy,
    output logic               frame_err
);

    localparam int CNT_W = $clog2(FRAME_MAX + 1);

    sched_state_t       state_q, state_d;
    logic               acs_en_q, acs_en_d;
    logic [1:0]         acs_pair_q, acs_pair_d;
    logic [SURV_AW-1:0] tb_last_addr_q, tb_last_addr_d;
    logic               frame_err_q, frame_err_d;
    logic               last_step_q, last_step_d;
    logic               tb_start_q, tb_start_d;

    logic               hs;
    logic               at_max;
    logic               last_now;
    logic               short_now;
    logic               ovf_now;
    logic [CNT_W-1:0]   step_cnt;
    logic [SURV_AW-1:0] waddr;

    vit_step_cnt #(
        .SURV_AW   (SURV_AW),
        .FRAME_MAX (FRAME_MAX),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q == ST_INIT),
        .step_i     (hs),
        .wr_i       (acs_en_q),
        .step_cnt_o (step_cnt),
        .waddr_o    (waddr),
        .at_max_o   (at_max)
    );

    assign hs        = in_valid && (state_q == ST_RUN);
    // The FRAME_MAX-th pair closes the frame even without in_last.
    assign last_now  = hs && (in_last || at_max);
    // step_cnt counts earlier pairs, so this frame has step_cnt+1 pairs.
    assign short_now = hs && in_last && (step_cnt < CNT_W'(TAIL));
    assign ovf_now   = hs && at_max && !in_last;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (in_valid) state_d = ST_INIT;
            ST_INIT:    state_d = ST_RUN;
            ST_RUN:     if (last_now) state_d = ST_TB_WAIT;
            ST_TB_WAIT: if (tb_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acs_en_d       = hs;
        acs_pair_d     = hs ? in_pair : acs_pair_q;
        // The step accepted now is written at index step_cnt.
        tb_last_addr_d = last_now ? SURV_AW'(step_cnt) : tb_last_addr_q;
        frame_err_d    = frame_err_q;
        if (state_q == ST_INIT)
            frame_err_d = 1'b0;
        else if (short_now || ovf_now)
            frame_err_d = 1'b1;
        // last_step_q marks the final acs_en; tb_start follows one cycle later.
        last_step_d    = last_now;
        tb_start_d     = last_step_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            acs_en_q       <= 1'b0;
            acs_pair_q     <= '0;
            tb_last_addr_q <= '0;
            frame_err_q    <= 1'b0;
            last_step_q    <= 1'b0;
            tb_start_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            acs_en_q       <= acs_en_d;
            acs_pair_q     <= acs_pair_d;
            tb_last_addr_q <= tb_last_addr_d;
            frame_err_q    <= frame_err_d;
            last_step_q    <= last_step_d;
            tb_start_q     <= tb_start_d;
        end
    end

    assign in_ready     = (state_q == ST_RUN);
    assign acs_init     = (state_q == ST_INIT);
    assign busy         = (state_q != ST_IDLE);
    assign acs_en       = acs_en_q;
    assign surv_we      = acs_en_q;
    assign acs_pair     = acs_pair_q;
    // Combinational from the ACS array so the clear lands on this same step.
    assign norm_en      = pm_all_msb && acs_en_q;
    assign surv_waddr   = waddr;
    assign tb_start     = tb_start_q;
    assign tb_last_addr = tb_last_addr_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_vit_acs_sched.sv
module tb_vit_acs_sched;

    localparam int TAIL = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid[2], in_ready[2], in_last[2], acs_en[2], acs_init[2];
    logic       pm_all_msb[2], norm_en[2], surv_we[2], tb_start[2], tb_done[2];
    logic       busy[2], frame_err[2];
    logic [1:0] in_pair[2], acs_pair[2];
    logic [9:0] surv_waddr[2], tb_last_addr[2];

    // Instance 0: default FRAME_MAX; instance 1: FRAME_MAX = 8 for overflow.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        vit_acs_sched #(
            .SURV_AW   (10),
            .FRAME_MAX (g == 0 ? 1000 : 8),
            .TAIL      (TAIL)
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .in_pair      (in_pair[g]),
            .in_last      (in_last[g]),
            .acs_en       (acs_en[g]),
            .acs_pair     (acs_pair[g]),
            .acs_init     (acs_init[g]),
            .pm_all_msb   (pm_all_msb[g]),
            .norm_en      (norm_en[g]),
            .surv_we      (surv_we[g]),
            .surv_waddr   (surv_waddr[g]),
            .tb_start     (tb_start[g]),
            .tb_last_addr (tb_last_addr[g]),
            .tb_done      (tb_done[g]),
            .busy         (busy[g]),
            .frame_err    (frame_err[g])
        );
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int sel         = 0;
    int exp_tb_cyc  = -100;
    int norm_cnt    = 0;
    bit spur_done   = 0;

    typedef struct {
        int         idx;
        logic [1:0] pair;
        int         cyc;
    } step_t;
    step_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted pair must appear as exactly one ACS step in
    // the following cycle, in order, at its 0-based index within the frame.
    always @(negedge clk) begin
        bit exp_en;
        if (rst_n) begin
            if (q.size() > 0 && q[0].cyc + 1 < cyc) begin
                chk("step_late", cyc, q[0].cyc + 1);
                void'(q.pop_front());
            end
            exp_en = (q.size() > 0) && (q[0].cyc + 1 == cyc);
            chk("acs_en", acs_en[sel], exp_en);
            chk("surv_we", surv_we[sel], exp_en);
            if (exp_en) begin
                chk("acs_pair", acs_pair[sel], q[0].pair);
                chk("surv_waddr", surv_waddr[sel], q[0].idx);
                void'(q.pop_front());
            end
            chk("norm_en", norm_en[sel], exp_en && pm_all_msb[sel]);
            if (norm_en[sel] === 1'b1) norm_cnt++;
            chk("tb_start", tb_start[sel], cyc == exp_tb_cyc);
        end
    end

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_in_ready"}, in_ready[d], 0);
            chk({tag, "_acs_en"}, acs_en[d], 0);
            chk({tag, "_acs_init"}, acs_init[d], 0);
            chk({tag, "_norm_en"}, norm_en[d], 0);
            chk({tag, "_surv_we"}, surv_we[d], 0);
            chk({tag, "_tb_start"}, tb_start[d], 0);
            chk({tag, "_busy"}, busy[d], 0);
            chk({tag, "_frame_err"}, frame_err[d], 0);
            chk({tag, "_acs_pair"}, acs_pair[d], 0);
            chk({tag, "_surv_waddr"}, surv_waddr[d], 0);
            chk({tag, "_tb_last_addr"}, tb_last_addr[d], 0);
        end
    endtask

    // One frame: n_drive pairs (in_last on the final one if has_last), a
    // stall of stall_len idle cycles before pair stall_at, optional random
    // bubbles, pm_all_msb raised on step msb_idx, reset on pair abort_idx,
    // and chain = next frame's valid raised together with tb_done.
    task automatic run_frame(input int n_drive, input bit has_last, input int stall_at,
                             input int stall_len, input bit rand_stall, input int fixed_val,
                             input int msb_idx, input int abort_idx, input bit chain);
        int         plan[$];
        logic [1:0] pv[$];
        int         fm, acc, acc_n, w, last_idx, norm0;
        bit         ovf, exp_err, msb_next, hold, exp_rdy;

        fm = (sel == 0) ? 1000 : 8;
        for (int i = 0; i < n_drive; i++)
            pv.push_back(fixed_val >= 0 ? 2'(fixed_val) : 2'($urandom_range(0, 3)));
        if (in_valid[sel] === 1'b1) pv[0] = in_pair[sel];
        for (int i = 0; i < n_drive; i++) begin
            if (i == stall_at)
                for (int b = 0; b < stall_len; b++) plan.push_back(-1);
            if (rand_stall && i > 0 && $urandom_range(0, 3) == 0) plan.push_back(-1);
            plan.push_back(i);
        end
        last_idx = has_last ? n_drive - 1 : -1;
        if (has_last && n_drive <= fm) begin
            acc = n_drive;
            ovf = 0;
        end else begin
            acc = fm;
            ovf = 1;
        end
        exp_err  = ovf || (acc < TAIL + 1);
        hold     = (n_drive > acc);
        msb_next = 0;
        q.delete();
        exp_tb_cyc = -100;

        if (in_valid[sel] !== 1'b1) begin
            @(posedge clk); #1;
            in_valid[sel] = 1'b1;
            in_pair[sel]  = pv[0];
        end
        in_last[sel] = (last_idx == 0);
        @(negedge clk);
        chk("idle_busy", busy[sel], 0);
        chk("idle_ready", in_ready[sel], 0);
        w = 0;
        while (acs_init[sel] !== 1'b1 && w < 6) begin
            @(negedge clk);
            w++;
        end
        chk("init_wait", w, 1);
        chk("init_ready", in_ready[sel], 0);
        chk("init_busy", busy[sel], 1);
        norm0 = norm_cnt;
        acc_n = 0;

        for (int s = 0; s < plan.size(); s++) begin
            @(posedge clk); #1;
            pm_all_msb[sel] = msb_next;
            msb_next        = 0;
            tb_done[sel]    = spur_done && (s == 2);
            in_valid[sel]   = (plan[s] >= 0);
            in_pair[sel]    = (plan[s] >= 0) ? pv[plan[s]] : 2'($urandom_range(0, 3));
            in_last[sel]    = (plan[s] >= 0) && (plan[s] == last_idx);
            if (plan[s] >= 0 && plan[s] == abort_idx) begin
                rst_n = 1'b0;
                #1;
                check_reset("abort");
                q.delete();
                exp_tb_cyc      = -100;
                in_valid[sel]   = 1'b0;
                in_last[sel]    = 1'b0;
                pm_all_msb[sel] = 1'b0;
                tb_done[sel]    = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            exp_rdy = (acc_n < acc);
            chk("run_ready", in_ready[sel], exp_rdy);
            if (s == 0) chk("err_cleared", frame_err[sel], 0);
            if (plan[s] >= 0 && exp_rdy) begin
                q.push_back('{idx: plan[s], pair: pv[plan[s]], cyc: cyc});
                if (plan[s] == msb_idx) msb_next = 1;
                acc_n++;
                if (acc_n == acc) exp_tb_cyc = cyc + 2;
            end
        end
        chk("accepted", acc_n, acc);

        // Final step, then tb_start one cycle later.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            pm_all_msb[sel] = msb_next;
            msb_next        = 0;
            tb_done[sel]    = 1'b0;
            in_valid[sel]   = hold;
            in_last[sel]    = 1'b0;
            @(negedge clk);
            chk("wait_ready", in_ready[sel], 0);
            chk("wait_busy", busy[sel], 1);
        end
        chk("tb_last_addr", tb_last_addr[sel], acc - 1);
        chk("frame_err", frame_err[sel], exp_err);
        chk("norm_count", norm_cnt - norm0, (msb_idx >= 0 && msb_idx < acc) ? 1 : 0);
        chk("steps_left", q.size(), 0);

        @(posedge clk); #1;
        pm_all_msb[sel] = 1'b0;
        tb_done[sel]    = 1'b1;
        in_valid[sel]   = chain;
        in_last[sel]    = 1'b0;
        if (chain) in_pair[sel] = 2'($urandom_range(0, 3));
        @(negedge clk);
        chk("done_busy", busy[sel], 1);
        @(posedge clk); #1;
        tb_done[sel]  = 1'b0;
        in_valid[sel] = chain;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]   = 1'b0;
            in_pair[d]    = 2'b00;
            in_last[d]    = 1'b0;
            pm_all_msb[d] = 1'b0;
            tb_done[d]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle");

        sel = 0;
        // 10 pairs of 2'b11, in_last on pair 10
        run_frame(10, 1, -1, 0, 0, 3, -1, -1, 0);
        // 20 pairs with a three-cycle valid gap after pair 3
        run_frame(20, 1, 3, 3, 0, -1, -1, -1, 0);
        // pm_all_msb only during step 4
        run_frame(12, 1, -1, 0, 0, -1, 4, -1, 0);
        // stray tb_done outside TB_WAIT is ignored (IDLE, then RUN)
        @(posedge clk); #1;
        tb_done[0] = 1'b1;
        @(negedge clk);
        chk("stray_done_idle", busy[0], 0);
        @(posedge clk); #1;
        tb_done[0] = 1'b0;
        spur_done  = 1;
        run_frame(9, 1, -1, 0, 0, -1, -1, -1, 0);
        spur_done  = 0;
        // short-frame boundary: TAIL+1 pairs is legal, fewer is an error
        run_frame(3, 1, -1, 0, 0, -1, -1, -1, 0);
        run_frame(7, 1, -1, 0, 0, -1, -1, -1, 0);
        run_frame(6, 1, -1, 0, 0, -1, -1, -1, 0);
        // reset during pair 5, then a clean frame from address 0
        run_frame(10, 1, -1, 0, 0, -1, -1, 4, 0);
        run_frame(10, 1, -1, 0, 0, -1, -1, -1, 0);
        // tb_done coincident with the next frame's in_valid
        run_frame(8, 1, -1, 0, 0, -1, -1, -1, 1);
        run_frame(11, 1, -1, 0, 0, -1, -1, -1, 0);
        // randomized frames with random bubbles and normalisation requests
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(7, 40), 1, -1, 0, 1, -1, $urandom_range(0, 6), -1,
                      (f < 5) && (f % 2 == 1));

        sel = 1;
        // FRAME_MAX = 8 without in_last: overflow on pair 8, pair 9 held off
        run_frame(9, 0, -1, 0, 0, -1, -1, -1, 0);
        // exactly FRAME_MAX pairs with in_last is a legal frame
        run_frame(8, 1, -1, 0, 0, -1, 2, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
